// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACC_CPU  = 3'd1,
    ACC_DMA  = 3'd2,
    RESP_CPU = 3'd3,
    RESP_DMA = 3'd4
  } state_e;

  localparam int unsigned STARVE_W   = 4;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-side signals of the arbiter; slave = arbiter, master = environment.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cpu_ce;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_done;
  logic                  mem_ce;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  bus_err;

  modport slave (
    input  cpu_ce, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, dma_rdata, dma_done,
    output mem_ce, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output cpu_ce, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, dma_rdata, dma_done,
    input  mem_ce, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/dmem_arbiter_watchdog.sv
// Access watchdog: counts cycles while start_i is high, expires on the last allowed cycle.
module dmem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic start_i,
  output logic expire_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // cnt_q holds cycles already spent, so TIMEOUT_CYCLES-1 marks the final one
  assign expire_o = start_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between CPU MEM stage and a DMA master.
// Optional access watchdog enabled with `define DMEM_TIMEOUT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_e                state_q;
  logic [STARVE_W-1:0]   starve_q;
  logic                  mem_ce_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  dma_done_q;
  logic                  bus_err_q;
  logic                  expire;
  logic                  in_acc;
  logic                  dma_forced;

  assign in_acc     = (state_q == ACC_CPU) || (state_q == ACC_DMA);
  assign dma_forced = bus.dma_req && (starve_q == STARVE_W'(STARVE_MAX));

`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (!in_acc),
    .start_i  (in_acc),
    .expire_o (expire)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      mem_ce_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      dma_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      dma_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_ce && !dma_forced) begin
            we_q     <= bus.cpu_we;
            addr_q   <= bus.cpu_addr;
            wdata_q  <= bus.cpu_wdata;
            mem_ce_q <= 1'b1;
            state_q  <= ACC_CPU;
            if (bus.dma_req && (starve_q != STARVE_W'(STARVE_MAX))) starve_q <= starve_q + 1'b1;
          end else if (bus.dma_req) begin
            we_q     <= bus.dma_we;
            addr_q   <= bus.dma_addr;
            wdata_q  <= bus.dma_wdata;
            mem_ce_q <= 1'b1;
            starve_q <= '0;
            state_q  <= ACC_DMA;
          end
        end
        ACC_CPU, ACC_DMA: begin
          // mem_ready takes priority over an expiry in the same cycle
          if (bus.mem_ready || expire) begin
            mem_ce_q <= 1'b0;
            if (bus.mem_ready) begin
              if (!we_q) rdata_q <= bus.mem_rdata;
            end else begin
              rdata_q   <= DATA_WIDTH'(ABORT_DATA);
              bus_err_q <= 1'b1;
            end
            if (state_q == ACC_CPU) begin
              state_q <= RESP_CPU;
            end else begin
              state_q    <= RESP_DMA;
              dma_done_q <= 1'b1;
            end
          end
        end
        RESP_CPU, RESP_DMA: state_q <= IDLE;
        default:            state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall = bus.cpu_ce && (state_q != RESP_CPU);
  assign bus.cpu_rdata = (state_q == RESP_CPU) ? rdata_q : '0;
  assign bus.dma_rdata = (state_q == RESP_DMA) ? rdata_q : '0;
  assign bus.dma_done  = dma_done_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = we_q && mem_ce_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the pipeline MEM stage and the single-ported data memory; shares the memory between the CPU and a second master (DMA/program loader).
- Sequences each access as a multi-cycle transaction against a memory with a ready handshake.
- Stalls the pipeline until a CPU access has completed.

Parameters:
- DATA_WIDTH, 32, data bus width (matches REG_DATA_WIDTH).
- ADDR_WIDTH, 32, address width.
- STARVE_MAX, 4, consecutive CPU grants allowed while the DMA waits before the DMA is forced in; range 1..15.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- cpu_ce  in  1  CPU access request from MEM; level, held while stalled.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU store data.
- cpu_rdata  out  DATA_WIDTH  CPU load data; valid while state = RESP_CPU.
- cpu_stall  out  1  freezes IF/ID/EX/MEM.
- dma_req  in  1  DMA request; level, held with stable fields until dma_done.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_WIDTH  DMA address.
- dma_wdata  in  DATA_WIDTH  DMA store data.
- dma_rdata  out  DATA_WIDTH  DMA load data; valid with dma_done.
- dma_done  out  1  one-cycle completion pulse.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completes the current access in this cycle.
- bus_err  out  1  timeout flag; pulses in the RESP state of an aborted access.

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0, rdata_q 0. Reset is asynchronous: mem_ce falls immediately, even mid-access, and the access is abandoned with no completion reported.
- States: IDLE, ACC_CPU, ACC_DMA, RESP_CPU, RESP_DMA.
- IDLE:
  - Only cpu_ce: latch CPU we/addr/wdata -> ACC_CPU.
  - Only dma_req: latch DMA fields -> ACC_DMA.
  - Both: CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - Neither: stay in IDLE.
- ACC_x: mem_ce = 1; mem_we/addr/wdata driven from the latched registers and stable for the whole state. On mem_ready: for a read, rdata_q <= mem_rdata; for a write, rdata_q is unchanged. Then -> RESP_x. Without mem_ready, stay in ACC_x.
- RESP_CPU: cpu_rdata = rdata_q; -> IDLE.
- RESP_DMA: dma_done = 1, dma_rdata = rdata_q; -> IDLE. The arbiter does not re-sample dma_req until it is back in IDLE.
- cpu_stall = cpu_ce & (state != RESP_CPU), combinational, so it is high in the IDLE cycle a request first appears. Minimum CPU access is 3 cycles (IDLE, ACC, RESP) when mem_ready comes in the first ACC cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each CPU grant made while dma_req = 1.
  - Clears on a DMA grant.
  - Holds when dma_req = 0 at the time of a CPU grant.
- mem_ce is never asserted outside ACC states. No back-to-back issue: at least one idle memory cycle between accesses (the RESP state).
- A CPU request arriving while a DMA access is in flight stalls until the DMA RESP completes, then is granted in IDLE.
- cpu_ce dropping mid-access (pipeline flush) does not abort the access; it completes and the result is discarded.
- mem_ready outside ACC states is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in ACC_x. At TIMEOUT_CYCLES without mem_ready, the arbiter goes to RESP_x with rdata_q = 32'hDEADBEEF and bus_err = 1 for that RESP cycle.
  - The counter clears on each state change.
  - If mem_ready arrives in the same cycle as the limit, mem_ready wins and there is no error.
- Undefined: the arbiter waits indefinitely and bus_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding constants;
  - the DEADBEEF abort constant;
  - the STARVE_MAX counter width (4 bits).
- One natural sub-module, dmem_watchdog: counter, clear, start, expire. It is instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Reset: hold rst=0 mid ACC_CPU -> mem_ce=0 within the same cycle, cpu_stall=cpu_ce, all other outputs 0; after release, state IDLE.
- CPU read: cpu_ce=1, we=0, addr=0x100; mem_ready in the first ACC cycle with rdata=0x12345678 -> cpu_stall high for 2 cycles, RESP_CPU shows cpu_rdata=0x12345678, stall low.
- Wait states: CPU write addr=0x200, data=0xA5A5A5A5, mem_ready after 5 ACC cycles -> mem_we/addr/wdata stable throughout, rdata_q unchanged, stall held for 6 cycles.
- Fairness: cpu_ce and dma_req held continuously with STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DMA,CPU...; dma_done pulses once per DMA access.
- Contention: dma_req granted, cpu_ce rises during ACC_DMA -> CPU stalls until RESP_DMA, is granted in the following IDLE, no mem_ce overlap.
- Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ready never asserted on a CPU read -> after 8 ACC cycles, RESP_CPU with cpu_rdata=0xDEADBEEF, bus_err=1 for one cycle; ready coinciding with cycle 8 -> normal data, bus_err=0.
